// File: rtl/mdct_frame_fetch.sv
`default_nettype none
/////////////////////////////////////////////////////////////////////////////
// mdct_frame_fetch: windowed frame fetch from sample memory to MDCT stream
// Revision 1.0
/////////////////////////////////////////////////////////////////////////////
module mdct_frame_fetch #(
  parameter int FRAME_LEN = 256,
  parameter int DW        = 16,
  parameter int AW        = 14
) (
  input  logic                         clk_in,
  input  logic                         rst,
  input  logic                         soft_rstn,
  input  logic                         start,
  input  logic [AW-1:0]                start_addr,
  output logic                         finish,
  output logic                         busy,
  output logic                         mem_rd_en,
  output logic [AW-1:0]                mem_rd_addr,
  input  logic [DW-1:0]                mem_rd_data,
  output logic [$clog2(FRAME_LEN)-1:0] win_addr,
  input  logic [DW-1:0]                win_data,
  output logic                         out_valid,
  output logic [DW-1:0]                out_data,
  output logic                         out_last,
  input  logic                         out_ready
);
  localparam int c_kw = $clog2(FRAME_LEN);
  localparam int c_pw = 2 * DW;
  localparam logic [c_kw-1:0]        c_klast = c_kw'(FRAME_LEN - 1);
  localparam logic signed [c_pw-1:0] c_half  = c_pw'(1) << (DW - 2);
  localparam logic signed [c_pw-1:0] c_smax  = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [c_pw-1:0] c_smin  = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [AW-1:0]   r_base;
  logic [c_kw-1:0] r_k;
  logic            r_pend;
  logic            r_pend_last;
  logic [DW-1:0]   r_fifo_data [2];
  logic            r_fifo_last [2];
  logic            r_wptr;
  logic            r_rptr;
  logic [1:0]      r_cnt;

  logic                   w_pop;
  logic                   w_issue;
  logic                   w_issue_last;
  logic                   w_accept;
  logic [1:0]             w_commit;
  logic signed [c_pw-1:0] w_prod;
  logic signed [c_pw-1:0] w_round;
  logic signed [c_pw-1:0] w_shift;
  logic [DW-1:0]          w_sat;

  // Slots committed after this edge: FIFO entries plus the read now returning, minus the pop.
  assign w_pop        = out_valid & out_ready;
  assign w_commit     = r_cnt + {1'b0, r_pend} - {1'b0, w_pop};
  assign w_issue      = (r_state == S_RUN) && soft_rstn && (w_commit < 2'd2);
  assign w_issue_last = w_issue && (r_k == c_klast);
  assign w_accept     = (r_state == S_IDLE) && start && soft_rstn;

  assign w_prod  = c_pw'($signed(mem_rd_data)) * c_pw'($signed(win_data));
  assign w_round = w_prod + c_half;
  assign w_shift = w_round >>> (DW - 1);

  always_comb begin
    w_sat = w_shift[DW-1:0];
    if (w_shift > c_smax) begin
      w_sat = {1'b0, {(DW-1){1'b1}}};
    end else if (w_shift < c_smin) begin
      w_sat = {1'b1, {(DW-1){1'b0}}};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_issue_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_pop && out_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (!soft_rstn) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_base         <= '0;
      r_k            <= '0;
      r_pend         <= 1'b0;
      r_pend_last    <= 1'b0;
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_last[0] <= 1'b0;
      r_fifo_last[1] <= 1'b0;
      r_wptr         <= 1'b0;
      r_rptr         <= 1'b0;
      r_cnt          <= 2'd0;
    end else if (!soft_rstn) begin
      // Dropping r_pend discards any read data still returning.
      r_k         <= '0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_cnt       <= 2'd0;
    end else begin
      if (w_accept) begin
        r_base <= start_addr;
        r_k    <= '0;
      end else if (w_issue) begin
        r_k <= r_k + c_kw'(1);
      end
      r_pend      <= w_issue;
      r_pend_last <= w_issue_last;
      if (r_pend) begin
        r_fifo_data[r_wptr] <= w_sat;
        r_fifo_last[r_wptr] <= r_pend_last;
        r_wptr              <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_cnt <= w_commit;
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign finish      = (r_state == S_DONE);
  assign mem_rd_en   = w_issue;
  assign mem_rd_addr = r_base + AW'(r_k);
  assign win_addr    = r_k;
  assign out_valid   = (r_cnt != 2'd0);
  assign out_data    = r_fifo_data[r_rptr];
  assign out_last    = out_valid & r_fifo_last[r_rptr];

endmodule
`default_nettype wire

// File: tb/tb_mdct_frame_fetch.sv
`default_nettype none
// Bench for mdct_frame_fetch: directed frames with scoreboarded samples and read addresses.
module tb_mdct_frame_fetch;
  localparam int L  = 8;
  localparam int DW = 16;
  localparam int AW = 14;
  localparam int KW = $clog2(L);

  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic          soft_rstn = 1'b1;
  logic          start = 1'b0;
  logic          out_ready;
  logic [AW-1:0] start_addr = '0;
  logic          finish, busy, mem_rd_en, out_valid, out_last;
  logic [AW-1:0] mem_rd_addr;
  logic [KW-1:0] win_addr;
  logic [DW-1:0] mem_rd_data, win_data, out_data;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] win [0:L-1];

  int checks = 0, errors = 0;
  int cyc = 0, t0 = 0, fc = 0;
  int n_fin = 0, n_out = 0, n_iss = 0, n_acc = 0, max_out = 0;
  bit rand_ready = 1'b0;
  logic [DW:0]   exp_q[$];
  logic [AW-1:0] addr_q[$];
  logic          hold_v = 1'b0;
  logic [DW:0]   hold_d = '0;

  mdct_frame_fetch #(.FRAME_LEN(L), .DW(DW), .AW(AW)) dut (
    .clk_in(clk_in), .rst(rst), .soft_rstn(soft_rstn), .start(start),
    .start_addr(start_addr), .finish(finish), .busy(busy),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .win_addr(win_addr), .win_data(win_data), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  always @(posedge clk_in) begin
    if (mem_rd_en) begin
      mem_rd_data <= mem[mem_rd_addr];
      win_data    <= win[win_addr];
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk_in); #1;
      out_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] wmul(input logic [15:0] s, input logic [15:0] w);
    longint p;
    p = longint'($signed(s)) * longint'($signed(w));
    p = (p + 64'sd16384) >>> 15;
    if (p > 64'sd32767) return 16'h7FFF;
    if (p < -64'sd32768) return 16'h8000;
    return p[15:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: read addresses, output samples, hold stability, finish pulses, outstanding depth.
  always @(negedge clk_in) begin
    if (finish) n_fin++;
    if (mem_rd_en) begin
      n_iss++;
      if (addr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_read: got addr %h, expected no read", mem_rd_addr);
      end else begin
        chk("rd_addr", 32'(mem_rd_addr), 32'(addr_q.pop_front()));
      end
    end
    if (hold_v) chk("hold_stable", 32'({out_valid, out_last, out_data}), 32'({1'b1, hold_d}));
    if (out_valid && out_ready) begin
      n_acc++; n_out++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got %h, expected no output", out_data);
      end else begin
        chk("out_sample", 32'({out_last, out_data}), 32'(exp_q.pop_front()));
      end
    end
    hold_v = out_valid && !out_ready;
    hold_d = {out_last, out_data};
    if (n_iss - n_acc > max_out) max_out = n_iss - n_acc;
  end

  task automatic push_addrs(input logic [AW-1:0] base);
    for (int k = 0; k < L; k++) addr_q.push_back(base + AW'(k));
  endtask

  task automatic push_model(input logic [AW-1:0] base);
    logic [AW-1:0] a;
    push_addrs(base);
    for (int k = 0; k < L; k++) begin
      a = base + AW'(k);
      exp_q.push_back({(k == L - 1), wmul(mem[a], win[k])});
    end
  endtask

  task automatic do_start(input logic [AW-1:0] base);
    @(posedge clk_in); #1;
    start = 1'b1; start_addr = base;
    @(posedge clk_in); #1;
    start = 1'b0; t0 = cyc;
  endtask

  task automatic wait_finish(input int budget, output int f);
    int n;
    n = 0; f = -1;
    while (n < budget && f < 0) begin
      @(negedge clk_in); #1;
      if (finish) f = cyc;
      n++;
    end
    if (f < 0) begin
      checks++; errors++;
      $display("FAIL finish_timeout: got no finish, expected one within %0d cycles", budget);
    end
  endtask

  task automatic flush();
    exp_q.delete(); addr_q.delete();
    n_iss = 0; n_acc = 0;
  endtask

  logic [DW-1:0] hand_wrap [0:L-1];
  int n0, b, f0;

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = DW'(a);
    for (int k = 0; k < L; k++) win[k] = 16'h7FFF;
    hand_wrap = '{16'h3FFC, 16'h3FFD, 16'h3FFE, 16'h3FFF, 16'h0000, 16'h7FFF, 16'h0002, 16'h0003};

    // Reset values while rst is asserted
    @(negedge clk_in); @(negedge clk_in);
    chk("rst_finish", 32'(finish), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
    chk("rst_win_addr", 32'(win_addr), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    rst = 1'b0;

    // Basic frame: value * 0x7FFF rounds back to value
    push_addrs(14'h0010);
    for (int k = 0; k < L; k++) exp_q.push_back({(k == L - 1), 16'h0010 + 16'(k)});
    do_start(14'h0010);
    @(negedge clk_in);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_rd_en", 32'(mem_rd_en), 32'd1);
    chk("t1_win_addr", 32'(win_addr), 32'd0);
    @(negedge clk_in);
    chk("t2_no_valid", 32'(out_valid), 32'd0);
    @(negedge clk_in);
    chk("t3_valid", 32'(out_valid), 32'd1);
    wait_finish(50, fc);
    chk("finish_cycle", 32'(fc), 32'(t0 + L + 2));
    chk("busy_at_finish", 32'(busy), 32'd1);
    @(negedge clk_in); #1;
    chk("finish_width", 32'(finish), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    chk("basic_drained", 32'(exp_q.size() + addr_q.size()), 32'd0);

    // Address wrap and -1 * -1 saturation
    mem[1] = 16'h8000; win[5] = 16'h8000;
    push_addrs(14'h3FFC);
    for (int k = 0; k < L; k++) exp_q.push_back({(k == L - 1), hand_wrap[k]});
    do_start(14'h3FFC);
    wait_finish(50, fc);
    chk("wrap_drained", 32'(exp_q.size() + addr_q.size()), 32'd0);
    mem[1] = 16'h0001; win[5] = 16'h7FFF;

    // Start while busy is ignored; start right after finish is accepted
    push_model(14'h0200);
    do_start(14'h0200);
    @(posedge clk_in); @(posedge clk_in); #1;
    start = 1'b1; start_addr = 14'h1000;
    @(posedge clk_in); #1;
    start = 1'b0;
    wait_finish(50, fc);
    chk("one_finish_each", 32'(n_fin), 32'd3);
    win = '{16'h7FFF, 16'h4000, 16'hC000, 16'h8000, 16'h0001, 16'h1234, 16'hFFFF, 16'h2000};
    push_model(14'h0300);
    do_start(14'h0300);
    @(negedge clk_in);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_finish(50, fc);
    chk("b2b_finish_cycle", 32'(fc), 32'(t0 + L + 2));

    // Backpressure at ~30% ready duty with signed data
    mem[14'h3FFA] = 16'h8000; mem[14'h3FFB] = 16'hFFFF; mem[14'h3FFD] = 16'h7FFF;
    @(posedge clk_in); #1;
    flush(); max_out = 0; f0 = n_fin;
    rand_ready = 1'b1;
    push_model(14'h3FF9); do_start(14'h3FF9); wait_finish(400, fc);
    push_model(14'h0123); do_start(14'h0123); wait_finish(400, fc);
    push_model(14'h2000); do_start(14'h2000); wait_finish(400, fc);
    rand_ready = 1'b0;
    chk("bp_finishes", 32'(n_fin - f0), 32'd3);
    chk("bp_drained", 32'(exp_q.size() + addr_q.size()), 32'd0);
    chk("bp_max_outstanding", 32'(max_out <= 2), 32'd1);
    for (int k = 0; k < L; k++) win[k] = 16'h7FFF;

    // Soft clear mid-frame
    push_model(14'h0400);
    do_start(14'h0400);
    n0 = n_out; b = 0;
    while (n_out < n0 + 4 && b < 50) begin @(negedge clk_in); #1; b++; end
    chk("soft_reach_sample", 32'(n_out >= n0 + 4), 32'd1);
    @(posedge clk_in); #1;
    soft_rstn = 1'b0;
    @(posedge clk_in); #1;
    soft_rstn = 1'b1;
    flush(); f0 = n_fin;
    @(negedge clk_in);
    chk("soft_out_valid", 32'(out_valid), 32'd0);
    chk("soft_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clk_in);
    chk("soft_no_finish", 32'(n_fin), 32'(f0));
    push_model(14'h0400);
    do_start(14'h0400);
    wait_finish(50, fc);
    chk("soft_refetch_drained", 32'(exp_q.size() + addr_q.size()), 32'd0);

    // Asynchronous reset between edges during DRAIN
    push_model(14'h0500);
    do_start(14'h0500);
    repeat (9) @(negedge clk_in);
    #2;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    f0 = n_fin;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_out_last", 32'(out_last), 32'd0);
    chk("arst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("arst_rd_addr", 32'(mem_rd_addr), 32'd0);
    chk("arst_win_addr", 32'(win_addr), 32'd0);
    chk("arst_finish", 32'(finish), 32'd0);
    #1;
    rst = 1'b0;
    flush();
    repeat (10) @(negedge clk_in);
    chk("arst_no_finish", 32'(n_fin), 32'(f0));
    chk("arst_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdct_frame_fetch.md
# mdct_frame_fetch

Engine-side responder to the audio-compress process controller. It accepts a one-cycle start request with a 14-bit music base address and fetches one frame of FRAME_LEN samples from sample memory. Each sample is multiplied by a Q1.15 window coefficient from the window ROM, and the windowed samples are streamed to the MDCT datapath over a valid/ready interface. After the last sample is accepted it returns a one-cycle `finish` pulse to the controller.

## Interface
Parameters:
- FRAME_LEN, 256: samples per frame (2N for an N-point MDCT); power of two, 4..4096.
- DW, 16: sample and coefficient width, both signed two's complement.
- AW, 14: sample memory address width.

Ports:
- clk_in  input  1  single clock; all logic on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- soft_rstn  input  1  synchronous active-low engine clear, driven by the controller.
- start  input  1  frame request, sampled on rising edge.
- start_addr  input  AW  base address of the frame, sampled with `start`.
- finish  output  1  one-cycle pulse when the frame is complete.
- busy  output  1  high from the accepted start until the finish pulse, inclusive.
- mem_rd_en  output  1  sample memory read strobe.
- mem_rd_addr  output  AW  sample memory read address.
- mem_rd_data  input  DW  read data, valid 1 cycle after `mem_rd_en`.
- win_addr  output  log2(FRAME_LEN)  window ROM address, issued with `mem_rd_en`.
- win_data  input  DW  window coefficient (Q1.15), valid 1 cycle after issue.
- out_valid  output  1  windowed sample available.
- out_data  output  DW  windowed sample (Q1.15).
- out_last  output  1  high with the final sample of the frame.
- out_ready  input  1  downstream accept.

## Operation
- States:
  - IDLE: no activity.
  - RUN: reads are being issued.
  - DRAIN: all reads issued, waiting for the output to empty.
  - DONE: one cycle; asserts `finish`.
- Transitions:
  - IDLE -> RUN on `start` and `soft_rstn` both high; latches `start_addr`.
  - RUN -> DRAIN after read index FRAME_LEN-1 is issued.
  - DRAIN -> DONE when the last sample is accepted (`out_valid & out_ready & out_last`).
  - DONE -> IDLE unconditionally.
- `start` outside IDLE is ignored; no queuing, no error.
- Read index k runs 0..FRAME_LEN-1.
  - `mem_rd_addr` = latched base + k, modulo 2^AW, so a frame may wrap from 0x3FFF to 0x0000.
  - `win_addr` = k.
- Pipeline: issue (k) -> data return -> multiply/round register -> 2-entry output FIFO.
- Flow control: a read issues only when FIFO occupancy + reads in flight < 2. No sample is ever dropped or duplicated under any `out_ready` pattern.
- Arithmetic:
  - p = mem_rd_data * win_data, a 2·DW-bit signed product.
  - out = (p + 2^(DW-2)) >>> (DW-1), then saturated to DW bits.
  - The only overflow case is -32768 × -32768, which saturates to 0x7FFF.
- `out_last` is asserted with the sample for k = FRAME_LEN-1 only.
- `soft_rstn` low in any state:
  - next cycle the block is in IDLE, the FIFO is empty, the in-flight count is 0, and `out_valid` = 0;
  - no `finish` is generated;
  - read data returning after the clear is discarded.

## Timing
- Reset values: `finish` = 0, `busy` = 0, `mem_rd_en` = 0, `mem_rd_addr` = 0, `win_addr` = 0, `out_valid` = 0, `out_data` = 0, `out_last` = 0; state IDLE.
- `rst` takes effect immediately and asynchronously, at any point in a frame.
- With `start` high at edge t0:
  - `busy` and the first `mem_rd_en` are high in cycle t0+1;
  - data returns at t0+2;
  - first `out_valid` is at t0+3.
- With `out_ready` held high:
  - throughput is 1 sample/cycle;
  - the last sample is valid at t0+FRAME_LEN+2;
  - `finish` is high at t0+FRAME_LEN+3;
  - `busy` falls at t0+FRAME_LEN+4.
- `out_data`, `out_valid` and `out_last` are held stable while `out_valid & !out_ready`.
- `finish` is exactly 1 cycle wide. A new `start` is accepted the cycle after DONE, i.e. back-to-back frames have a 1-cycle gap.
- `start` is treated as level-sampled; a pulse spanning multiple cycles starts one frame only, because it is ignored once out of IDLE.

## Test plan
- Basic frame: FRAME_LEN=8, base 0x0010, memory[a] = a, window = 0x7FFF, `out_ready`=1 -> 8 outputs 0x0010..0x0017 (value·0x7FFF rounded), `out_last` on the 8th, `finish` at t0+11.
- Wrap and saturation: base 0x3FFC, FRAME_LEN=8 -> addresses 0x3FFC..0x3FFF then 0x0000..0x0003; a sample 0x8000 with window 0x8000 -> output 0x7FFF.
- Backpressure: random `out_ready` at 30% duty, FRAME_LEN=256 -> exactly 256 outputs, in order, matching the reference model; never more than 2 reads outstanding; one `finish`.
- Start while busy: second `start` with addr 0x1000 mid-frame -> ignored, with `mem_rd_addr` continuing from the original base; a `start` one cycle after `finish` -> new frame begins.
- Soft clear mid-frame: `soft_rstn` low at sample 100 -> `out_valid` = 0 the next cycle, `busy` = 0, no `finish`; a subsequent `start` produces a complete correct frame.
- Async reset: `rst` pulsed between clock edges during DRAIN -> all outputs go to their reset values immediately; no `finish`.
